// File: rtl/fetch_npc_unit.sv
// Fetch stage: PC register, next-PC selection and the F/D pipeline register.
// Redirects use the instruction currently in D; the instruction in F at that
// time (the delay slot) always moves on to D, so there is no flush path.
module fetch_npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_index26,
    input  logic [31:0] d_rs_value,
    input  logic [31:0] f_instr,
    output logic [31:0] f_pc,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8
);

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JREG   = 2'd3
    } npc_op_t;

    logic [31:0] pc_q;
    logic [31:0] d_instr_q;
    logic [31:0] d_pc_q;

    logic [31:0] f_pc_plus4;
    logic [31:0] d_pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jump_target;
    logic [31:0] npc;
    npc_op_t     op;

    assign op          = npc_op_t'(npc_op);
    assign f_pc_plus4  = pc_q + 32'd4;
    assign d_pc_plus4  = d_pc_q + 32'd4;
    assign br_offset   = {{14{d_imm16[15]}}, d_imm16, 2'b00};
    assign br_target   = d_pc_plus4 + br_offset;
    assign jump_target = {d_pc_plus4[31:28], d_index26, 2'b00};

    // Next-PC select; branch_taken only matters for conditional branches
    always_comb begin
        npc = f_pc_plus4;
        case (op)
            NPC_SEQ:    npc = f_pc_plus4;
            NPC_BRANCH: npc = branch_taken ? br_target : f_pc_plus4;
            NPC_JUMP:   npc = jump_target;
            NPC_JREG:   npc = d_rs_value;
            default:    npc = f_pc_plus4;
        endcase
    end

    // PC and F/D register: reset beats stall, stall freezes everything
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            d_instr_q <= '0;
            d_pc_q    <= '0;
        end else if (!stall) begin
            pc_q      <= npc;
            d_instr_q <= f_instr;
            d_pc_q    <= pc_q;
        end
    end

    assign f_pc    = pc_q;
    assign d_instr = d_instr_q;
    assign d_pc    = d_pc_q;
    assign d_pc8   = d_pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Self-checking bench for fetch_npc_unit: directed cases plus randomized
// stimulus checked against a behavioural model of the fetch stage.
module tb_fetch_npc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        branch_taken;
    logic [15:0] d_imm16;
    logic [25:0] d_index26;
    logic [31:0] d_rs_value;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model state
    logic [31:0] m_pc;
    logic [31:0] m_di;
    logic [31:0] m_dp;

    fetch_npc_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .npc_op       (npc_op),
        .branch_taken (branch_taken),
        .d_imm16      (d_imm16),
        .d_index26    (d_index26),
        .d_rs_value   (d_rs_value),
        .f_instr      (f_instr),
        .f_pc         (f_pc),
        .d_instr      (d_instr),
        .d_pc         (d_pc),
        .d_pc8        (d_pc8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Target computed with wide signed arithmetic, reduced modulo 2^32
    function automatic logic [31:0] model_npc(input logic [1:0] op, input logic bt,
                                              input logic [15:0] imm, input logic [25:0] idx,
                                              input logic [31:0] rs);
        longint t;
        longint off;
        off = longint'($signed(imm));
        case (op)
            2'd1:    t = bt ? (longint'(m_dp) + 4 + off * 4) : (longint'(m_pc) + 4);
            2'd2:    t = ((longint'(m_dp) + 4) % 64'h1_0000_0000) / 64'h1000_0000 * 64'h1000_0000
                         + longint'(idx) * 4;
            2'd3:    t = longint'(rs);
            default: t = longint'(m_pc) + 4;
        endcase
        t = t % 64'h1_0000_0000;
        if (t < 0) t = t + 64'h1_0000_0000;
        return t[31:0];
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".f_pc"},    f_pc,    m_pc);
        check({tag, ".d_instr"}, d_instr, m_di);
        check({tag, ".d_pc"},    d_pc,    m_dp);
        check({tag, ".d_pc8"},   d_pc8,   m_dp + 32'd8);
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic cycle(input string tag, input logic r, input logic s, input logic [1:0] op,
                         input logic bt, input logic [15:0] imm, input logic [25:0] idx,
                         input logic [31:0] rs, input logic [31:0] ins);
        logic [31:0] n_pc;
        reset = r; stall = s; npc_op = op; branch_taken = bt;
        d_imm16 = imm; d_index26 = idx; d_rs_value = rs; f_instr = ins;
        n_pc = model_npc(op, bt, imm, idx, rs);
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = RST_PC; m_di = '0; m_dp = '0;
        end else if (!s) begin
            m_dp = m_pc; m_di = ins; m_pc = n_pc;
        end
        check_model(tag);
    endtask

    task automatic seq(input string tag);
        cycle(tag, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'hA000_0000 ^ f_pc);
    endtask

    task automatic do_reset();
        cycle("rst", 1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; npc_op = 2'd0; branch_taken = 1'b0;
        d_imm16 = '0; d_index26 = '0; d_rs_value = '0; f_instr = '0;
        m_pc = '0; m_di = '0; m_dp = '0;

        // Reset state and free-running fetch
        do_reset();
        check("rst_fpc", f_pc, 32'h3000);
        check("rst_dinstr", d_instr, 32'h0);
        check("rst_dpc8", d_pc8, 32'h8);
        seq("seq1");
        check("seq1_fpc", f_pc, 32'h3004);
        check("seq1_dpc", d_pc, 32'h3000);
        seq("seq2");
        seq("seq3");
        check("seq3_fpc", f_pc, 32'h300C);

        // beq at 3004 taken / not taken
        do_reset(); seq("b0"); seq("b1");
        cycle("beq_t", 1'b0, 1'b0, 2'd1, 1'b1, 16'h0003, 26'h0, 32'h0, 32'hDEAD_3008);
        check("beq_t_fpc", f_pc, 32'h3014);
        check("beq_t_slot", d_pc, 32'h3008);
        check("beq_t_slot_instr", d_instr, 32'hDEAD_3008);
        do_reset(); seq("b2"); seq("b3");
        cycle("beq_nt", 1'b0, 1'b0, 2'd1, 1'b0, 16'h0003, 26'h0, 32'h0, 32'h0);
        check("beq_nt_fpc", f_pc, 32'h300C);

        // Negative offset from 3010
        do_reset();
        cycle("jr3010", 1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3010, 32'h0);
        seq("n1");
        cycle("bneg", 1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0, 32'h0);
        check("bneg_fpc", f_pc, 32'h3004);

        // Wrap-around from FFFF_FFFC
        do_reset();
        cycle("jrtop", 1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0);
        seq("w1");
        check("wrap_dpc", d_pc, 32'hFFFF_FFFC);
        cycle("bwrap", 1'b0, 1'b0, 2'd1, 1'b1, 16'h0000, 26'h0, 32'h0, 32'h0);
        check("bwrap_fpc", f_pc, 32'h0000_0000);

        // j and jalr with d_pc = 3000
        do_reset(); seq("j0");
        cycle("j", 1'b0, 1'b0, 2'd2, 1'b1, 16'h0, 26'h0000C10, 32'h0, 32'h0);
        check("j_fpc", f_pc, 32'h0000_3040);
        do_reset(); seq("jr0");
        check("jalr_dpc8", d_pc8, 32'h3008);
        cycle("jalr", 1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_4001, 32'h0);
        check("jalr_fpc", f_pc, 32'h0000_4001);

        // Stalled branch, branch_taken toggling, then release
        do_reset(); seq("s0"); seq("s1");
        cycle("stall0", 1'b0, 1'b1, 2'd1, 1'b0, 16'h0003, 26'h0, 32'h0, 32'h1111_1111);
        check("stall0_fpc", f_pc, 32'h3008);
        cycle("stall1", 1'b0, 1'b1, 2'd1, 1'b1, 16'h0003, 26'h0, 32'h0, 32'h2222_2222);
        check("stall1_fpc", f_pc, 32'h3008);
        check("stall1_dpc", d_pc, 32'h3004);
        cycle("release", 1'b0, 1'b0, 2'd1, 1'b1, 16'h0003, 26'h0, 32'h0, 32'h3333_3333);
        check("release_fpc", f_pc, 32'h3014);
        check("release_dpc", d_pc, 32'h3008);
        seq("after");
        check("after_fpc", f_pc, 32'h3018);

        // Reset with stall and a taken branch
        cycle("rst_mix", 1'b1, 1'b1, 2'd1, 1'b1, 16'h0003, 26'h0, 32'h0, 32'h5555_5555);
        check("rst_mix_fpc", f_pc, 32'h3000);
        check("rst_mix_dinstr", d_instr, 32'h0);
        check("rst_mix_dpc", d_pc, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle("rnd",
                  ($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  16'($urandom),
                  26'($urandom),
                  $urandom,
                  $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
